// File: rtl/instruction_fetch_unit_if.sv
// Fetch-stage bundle: instruction-memory request/response, execute redirect and
// decode-side delivery. The fetch unit is the master; memory/execute/decode are the slave.
interface instruction_fetch_unit_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_stall;
  logic        id_valid;
  logic [31:0] id_instruction;
  logic [31:0] id_pc;
  logic [31:0] id_pc_plus4;
  logic        fetch_misalign;

  modport master (
    output imem_req_valid, imem_req_addr, id_valid, id_instruction, id_pc, id_pc_plus4,
           fetch_misalign,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc, id_stall
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, id_valid, id_instruction, id_pc, id_pc_plus4,
           fetch_misalign,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc, id_stall
  );
endinterface

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the PC, keeps one imem read in flight, 1-entry skid for decode stalls.
// Optional FETCH_MISALIGN_TRAP_EN parks the unit on a misaligned redirect target.
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter logic [31:0] BUBBLE_INSTR = 32'h0000_0013
) (
  input  logic                      clk,
  input  logic                      reset,
  instruction_fetch_unit_if.master  bus
);

  typedef enum logic [2:0] {S_REQ, S_WAIT, S_HOLD, S_DRAIN, S_PARK} state_t;

  state_t      state, state_next;
  logic [31:0] pc, pc_next;
  logic [31:0] skid_instr, skid_pc;
  logic [31:0] redirect_target;
  logic        misalign_hit;
  logic        accept, inflight;
  logic        load_rsp, load_skid, fill_skid, clear_id;
  logic        id_valid;
  logic [31:0] id_instruction, id_pc, id_pc_plus4;

`ifdef FETCH_MISALIGN_TRAP_EN
  assign misalign_hit    = bus.redirect_valid && (bus.redirect_pc[1:0] != 2'b00);
  assign redirect_target = bus.redirect_pc;
`else
  assign misalign_hit    = 1'b0;
  assign redirect_target = bus.redirect_pc & 32'hFFFF_FFFC;
`endif

  assign bus.imem_req_valid = (state == S_REQ);
  assign bus.imem_req_addr  = pc;
  assign accept             = (state == S_REQ) && bus.imem_req_ready;
  // A request is still owed a response unless it returns in this very cycle.
  assign inflight = (((state == S_WAIT) || (state == S_DRAIN)) && !bus.imem_rsp_valid) || accept;

  always_comb begin
    state_next = state;
    pc_next    = pc;
    load_rsp   = 1'b0;
    load_skid  = 1'b0;
    fill_skid  = 1'b0;
    clear_id   = 1'b0;
    if (bus.redirect_valid) begin
      pc_next  = redirect_target;
      clear_id = 1'b1;
      if (misalign_hit)  state_next = S_PARK;
      else if (inflight) state_next = S_DRAIN;
      else               state_next = S_REQ;
    end else begin
      clear_id = !bus.id_stall;
      case (state)
        S_REQ: if (accept) state_next = S_WAIT;
        S_WAIT: begin
          if (bus.imem_rsp_valid) begin
            pc_next = pc + 32'd4;
            if (!id_valid || !bus.id_stall) begin
              load_rsp   = 1'b1;
              clear_id   = 1'b0;
              state_next = S_REQ;
            end else begin
              fill_skid  = 1'b1;
              state_next = S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (!bus.id_stall) begin
            load_skid  = 1'b1;
            clear_id   = 1'b0;
            state_next = S_REQ;
          end
        end
        S_DRAIN: if (bus.imem_rsp_valid) state_next = S_REQ;
        default: state_next = state;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= S_REQ;
    else       state <= state_next;
  end

  // ---- decode-facing registers and PC ----
  always_ff @(posedge clk) begin
    if (reset) begin
      pc             <= RESET_PC;
      id_valid       <= 1'b0;
      id_instruction <= BUBBLE_INSTR;
      id_pc          <= 32'h0000_0000;
      id_pc_plus4    <= 32'h0000_0004;
    end else begin
      pc <= pc_next;
      if (load_rsp) begin
        id_valid       <= 1'b1;
        id_instruction <= bus.imem_rsp_data;
        id_pc          <= pc;
        id_pc_plus4    <= pc + 32'd4;
      end else if (load_skid) begin
        id_valid       <= 1'b1;
        id_instruction <= skid_instr;
        id_pc          <= skid_pc;
        id_pc_plus4    <= skid_pc + 32'd4;
      end else if (clear_id) begin
        id_valid       <= 1'b0;
        id_instruction <= BUBBLE_INSTR;
      end
    end
  end

  // ---- skid entry: data only, validity is implied by S_HOLD ----
  always_ff @(posedge clk) begin
    if (fill_skid) begin
      skid_instr <= bus.imem_rsp_data;
      skid_pc    <= pc;
    end
  end

`ifdef FETCH_MISALIGN_TRAP_EN
  logic misalign;
  always_ff @(posedge clk) begin
    if (reset)                   misalign <= 1'b0;
    else if (bus.redirect_valid) misalign <= misalign_hit;
  end
  assign bus.fetch_misalign = misalign;
`else
  assign bus.fetch_misalign = 1'b0;
`endif

  assign bus.id_valid       = id_valid;
  assign bus.id_instruction = id_instruction;
  assign bus.id_pc          = id_pc;
  assign bus.id_pc_plus4    = id_pc_plus4;

endmodule
